// File: rtl/exe_unit_pkg.sv
// -----------------------------------------------------------------------------
// exe_unit_pkg
// Shared types for the execution-unit issuer and anything that talks to it:
//   oper_e         - 2-bit opcode of the combinational execution unit
//   issuer_state_e - sequencing states of the issuer
//   flags_t        - {error, carry} pair returned with each response
//   mask_flags()   - keeps only the flags that are meaningful for an opcode
// -----------------------------------------------------------------------------
package exe_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_CMP  = 2'd1,
    OP_SET  = 2'd2,
    OP_CONV = 2'd3
  } oper_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESPOND
  } issuer_state_e;

  typedef struct packed {
    logic error;
    logic carry;
  } flags_t;

  // Error is only defined for set/convert, carry only for add; whatever the
  // unit drives on those lines for other opcodes is noise.
  function automatic flags_t mask_flags(input oper_e oper, input logic error,
                                        input logic carry);
    flags_t f;
    f.error = ((oper == OP_SET) || (oper == OP_CONV)) ? error : 1'b0;
    f.carry = (oper == OP_ADD) ? carry : 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/exe_cmd_fifo.sv
// -----------------------------------------------------------------------------
// exe_cmd_fifo
// Command buffer for the issuer. Stores packed {argA, argB, oper} words.
// Show-ahead: o_rd_data always presents the head entry; i_pop advances it.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_wr_data  write request (ignored when full, even with a pop)
//   i_pop              advance head (ignored when empty)
//   o_rd_data          head entry
//   o_full, o_empty    occupancy flags
//   o_count            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module exe_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [2*WIDTH+1:0]     i_wr_data,
  input  logic                   i_pop,
  output logic [2*WIDTH+1:0]     o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 2 * WIDTH + 2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              push_ok,  pop_ok;

  assign o_full    = (count_q == CNT_W'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign o_rd_data = mem_q[rd_ptr_q];

  // Full refuses a push outright, so a simultaneous pop never makes room
  // within the same cycle.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned and a latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer increments wrap on their own.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/exe_unit_issuer.sv
// -----------------------------------------------------------------------------
// exe_unit_issuer
// Sequential front-end for the combinational execution unit. Commands are
// buffered in exe_cmd_fifo, driven to the unit from registers, and the unit's
// outputs are captured two cycles later (one full settle cycle) and returned
// over a valid/ready response channel, in command order.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready          command handshake
//   i_cmd_argA, i_cmd_argB, i_cmd_oper command payload
//   o_exe_argA, o_exe_argB, o_exe_oper registered drive to the unit
//   i_exe_result, i_exe_error, i_exe_carry   unit outputs
//   o_rsp_valid / i_rsp_ready          response handshake
//   o_rsp_result, o_rsp_error, o_rsp_carry, o_rsp_oper   response payload
//   o_busy                             work in flight or queued
// -----------------------------------------------------------------------------
module exe_unit_issuer
  import exe_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_argA,
  input  logic [WIDTH-1:0] i_cmd_argB,
  input  logic [1:0]       i_cmd_oper,
  output logic [WIDTH-1:0] o_exe_argA,
  output logic [WIDTH-1:0] o_exe_argB,
  output logic [1:0]       o_exe_oper,
  input  logic [WIDTH-1:0] i_exe_result,
  input  logic             i_exe_error,
  input  logic             i_exe_carry,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_error,
  output logic             o_rsp_carry,
  output logic [1:0]       o_rsp_oper,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------- FIFO
  logic [2*WIDTH+1:0] fifo_rd_data;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [WIDTH-1:0]   head_arga;
  logic [WIDTH-1:0]   head_argb;
  logic [1:0]         head_oper;

  exe_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (i_cmd_valid),
    .i_wr_data ({i_cmd_argA, i_cmd_argB, i_cmd_oper}),
    .i_pop     (fifo_pop),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (fifo_count)
  );

  assign {head_arga, head_argb, head_oper} = fifo_rd_data;
  assign o_cmd_ready = !fifo_full;

  // ------------------------------------------------------------ sequencer
  issuer_state_e    state_q,      state_d;
  logic [WIDTH-1:0] exe_arga_q,   exe_arga_d;
  logic [WIDTH-1:0] exe_argb_q,   exe_argb_d;
  oper_e            exe_oper_q,   exe_oper_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_error_q,  rsp_error_d;
  logic             rsp_carry_q,  rsp_carry_d;
  oper_e            rsp_oper_q,   rsp_oper_d;
  flags_t           cap_flags;

  assign cap_flags = mask_flags(exe_oper_q, i_exe_error, i_exe_carry);

  always_comb begin
    state_d      = state_q;
    exe_arga_d   = exe_arga_q;
    exe_argb_d   = exe_argb_q;
    exe_oper_d   = exe_oper_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_oper_d   = rsp_oper_q;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          exe_arga_d = head_arga;
          exe_argb_d = head_argb;
          exe_oper_d = oper_e'(head_oper);
          state_d    = ST_ISSUE;
        end
      end
      // Operands have been on the unit's inputs since the previous edge;
      // this cycle only lets its combinational path settle.
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rsp_result_d = i_exe_result;
        rsp_error_d  = cap_flags.error;
        rsp_carry_d  = cap_flags.carry;
        rsp_oper_d   = exe_oper_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Chain straight into the next command to keep one per 3 cycles.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            exe_arga_d = head_arga;
            exe_argb_d = head_argb;
            exe_oper_d = oper_e'(head_oper);
            state_d    = ST_ISSUE;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      exe_arga_q   <= '0;
      exe_argb_q   <= '0;
      exe_oper_q   <= OP_ADD;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_oper_q   <= OP_ADD;
    end else begin
      state_q      <= state_d;
      exe_arga_q   <= exe_arga_d;
      exe_argb_q   <= exe_argb_d;
      exe_oper_q   <= exe_oper_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_oper_q   <= rsp_oper_d;
    end
  end

  assign o_exe_argA   = exe_arga_q;
  assign o_exe_argB   = exe_argb_q;
  assign o_exe_oper   = exe_oper_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_error  = rsp_error_q;
  assign o_rsp_carry  = rsp_carry_q;
  assign o_rsp_oper   = rsp_oper_q;
  assign o_busy       = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_exe_unit_issuer.sv
// -----------------------------------------------------------------------------
// tb_exe_unit_issuer
// Self-checking bench for exe_unit_issuer. A behavioural execution unit drives
// the DUT's exe inputs; a scoreboard queue predicts every response from the
// accepted commands. Directed table vectors, hand-written corner sequences
// and a random phase share the same scoreboard.
// -----------------------------------------------------------------------------
module tb_exe_unit_issuer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_arga;
  logic [WIDTH-1:0] cmd_argb;
  logic [1:0]       cmd_oper;
  logic [WIDTH-1:0] exe_arga;
  logic [WIDTH-1:0] exe_argb;
  logic [1:0]       exe_oper;
  logic [WIDTH-1:0] exe_result;
  logic             exe_error;
  logic             exe_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_error;
  logic             rsp_carry;
  logic [1:0]       rsp_oper;
  logic             busy;

  // Extra error/carry forced onto the unit's outputs for directed tests.
  logic inj_err;
  logic inj_carry;

  exe_unit_issuer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_argA   (cmd_arga),
    .i_cmd_argB   (cmd_argb),
    .i_cmd_oper   (cmd_oper),
    .o_exe_argA   (exe_arga),
    .o_exe_argB   (exe_argb),
    .o_exe_oper   (exe_oper),
    .i_exe_result (exe_result),
    .i_exe_error  (exe_error),
    .i_exe_carry  (exe_carry),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_error  (rsp_error),
    .o_rsp_carry  (rsp_carry),
    .o_rsp_oper   (rsp_oper),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------ unit + ref model
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             error;
    logic             carry;
    logic [1:0]       oper;
  } rsp_t;

  // Behavioural execution unit: raw (unmasked) outputs.
  function automatic rsp_t unit_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] op, input logic ie, input logic ic);
    rsp_t u;
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0:    u.result = sum[WIDTH-1:0];
      2'd1:    u.result = a - b;
      2'd2:    u.result = b;
      default: u.result = ~a;
    endcase
    u.error = ie | (a[WIDTH-1] & b[WIDTH-1]);
    u.carry = ic | sum[WIDTH];
    u.oper  = op;
    return u;
  endfunction

  // Expected response: error kept for opcodes 2/3, carry for opcode 0.
  function automatic rsp_t ref_rsp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [1:0] op, input logic ie, input logic ic);
    rsp_t u;
    u = unit_fn(a, b, op, ie, ic);
    if (op < 2) u.error = 1'b0;
    if (op != 0) u.carry = 1'b0;
    return u;
  endfunction

  rsp_t unit_out;
  always_comb unit_out = unit_fn(exe_arga, exe_argb, exe_oper, inj_err, inj_carry);
  assign exe_result = unit_out.result;
  assign exe_error  = unit_out.error;
  assign exe_carry  = unit_out.carry;

  // ------------------------------------------------------------ checking
  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle, when all inputs are stable for the next edge.
  rsp_t exp_q[$];
  int   hs_times[$];
  int   n_rsp;
  logic prev_hold;
  rsp_t prev_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid",  64'(rsp_valid),  64'(1));
        check("hold_result", 64'(rsp_result), 64'(prev_rsp.result));
        check("hold_oper",   64'(rsp_oper),   64'(prev_rsp.oper));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check($sformatf("sb%0d_result", n_rsp), 64'(rsp_result), 64'(e.result));
          check($sformatf("sb%0d_error",  n_rsp), 64'(rsp_error),  64'(e.error));
          check($sformatf("sb%0d_carry",  n_rsp), 64'(rsp_carry),  64'(e.carry));
          check($sformatf("sb%0d_oper",   n_rsp), 64'(rsp_oper),   64'(e.oper));
        end
        hs_times.push_back(cyc);
        n_rsp++;
      end
      if (cmd_valid && cmd_ready)
        exp_q.push_back(ref_rsp(cmd_arga, cmd_argb, cmd_oper, inj_err, inj_carry));
      prev_hold = rsp_valid && !rsp_ready;
      prev_rsp  = '{result: rsp_result, error: rsp_error, carry: rsp_carry, oper: rsp_oper};
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_arga  = a;
    cmd_argb  = b;
    cmd_oper  = op;
  endtask

  task automatic rand_cmd();
    set_cmd($urandom, $urandom, 2'($urandom_range(0, 3)));
  endtask

  // Waits for o_rsp_valid; returns edges waited (timeout shows as 20).
  task automatic wait_rsp(input string name, output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check({name, "_rsp_seen"}, 64'(rsp_valid), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             ie;
    logic             ic;
    logic [WIDTH-1:0] exp_result;
    logic             exp_error;
    logic             exp_carry;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    int base;

    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         2'd0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[1] = '{32'h5,         32'h3,         2'd1, 1'b1, 1'b1, 32'h2,         1'b0, 1'b0};
    vecs[2] = '{32'h10,        32'hABCD,      2'd2, 1'b1, 1'b1, 32'hABCD,      1'b1, 1'b0};
    vecs[3] = '{32'h0000_FFFF, 32'h0,         2'd3, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 2'd0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[5] = '{32'h1,         32'h2,         2'd0, 1'b0, 1'b0, 32'h3,         1'b0, 1'b0};
    vecs[6] = '{32'h3,         32'h5,         2'd1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{32'h0,         32'h0,         2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0001, 2'd2, 1'b0, 1'b0, 32'h8000_0001, 1'b1, 1'b0};

    n_tests   = 0;
    n_fail    = 0;
    n_rsp     = 0;
    cyc       = 0;
    prev_hold = 1'b0;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_arga  = '0;
    cmd_argb  = '0;
    cmd_oper  = '0;
    rsp_ready = 1'b0;
    inj_err   = 1'b0;
    inj_carry = 1'b0;

    // ---- power-on reset
    #3 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---- reset while a response is waiting
    set_cmd(32'h1234, 32'h1, 2'd0);
    step();
    cmd_valid = 1'b0;
    wait_rsp("mid_rst", n);
    check("mid_rst_pre_result", 64'(rsp_result), 64'(32'h1235));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid",  64'(rsp_valid),  64'(0));
    check("mid_rst_rsp_result", 64'(rsp_result), 64'(0));
    check("mid_rst_rsp_oper",   64'(rsp_oper),   64'(0));
    check("mid_rst_exe_arga",   64'(exe_arga),   64'(0));
    check("mid_rst_exe_argb",   64'(exe_argb),   64'(0));
    check("mid_rst_cmd_ready",  64'(cmd_ready),  64'(1));
    check("mid_rst_busy",       64'(busy),       64'(0));
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 64'(busy), 64'(0));

    // ---- directed vectors: values and 3-cycle latency on an empty FIFO
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      inj_err   = vecs[i].ie;
      inj_carry = vecs[i].ic;
      check($sformatf("tbl%0d_ready", i), 64'(cmd_ready), 64'(1));
      set_cmd(vecs[i].a, vecs[i].b, vecs[i].op);
      step();
      cmd_valid = 1'b0;
      wait_rsp($sformatf("tbl%0d", i), n);
      check($sformatf("tbl%0d_latency", i), 64'(n),          64'(3));
      check($sformatf("tbl%0d_result", i),  64'(rsp_result), 64'(vecs[i].exp_result));
      check($sformatf("tbl%0d_error", i),   64'(rsp_error),  64'(vecs[i].exp_error));
      check($sformatf("tbl%0d_carry", i),   64'(rsp_carry),  64'(vecs[i].exp_carry));
      check($sformatf("tbl%0d_oper", i),    64'(rsp_oper),   64'(vecs[i].op));
      step();
    end
    inj_err   = 1'b0;
    inj_carry = 1'b0;
    wait_idle("tbl");
    // Operand registers keep the last command after going idle.
    check("exe_hold_arga", 64'(exe_arga), 64'(vecs[8].a));
    check("exe_hold_oper", 64'(exe_oper), 64'(vecs[8].op));

    // ---- fill: 5 pushes with the consumer stalled, then a refused 6th
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill%0d_ready", i), 64'(cmd_ready), 64'(1));
      rand_cmd();
      step();
    end
    rand_cmd();
    check("fill_full_ready", 64'(cmd_ready), 64'(0));
    step();
    step();
    check("fill_still_full", 64'(cmd_ready), 64'(0));
    check("fill_busy",       64'(busy),      64'(1));
    // Pop while full: the pending push must still be refused on this edge.
    rsp_ready = 1'b1;
    step();
    check("full_pop_ready", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
    wait_idle("fill");
    check("fill_rsp_count", 64'(n_rsp - base), 64'(6));

    // ---- sustained throughput across pointer wrap
    base = n_rsp;
    hs_times.delete();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tput%0d_ready", i), 64'(cmd_ready), 64'(1));
      rand_cmd();
      step();
    end
    cmd_valid = 1'b0;
    wait_idle("tput");
    check("tput_rsp_count", 64'(hs_times.size()), 64'(6));
    for (int i = 1; i < hs_times.size(); i++)
      check($sformatf("tput%0d_gap", i), 64'(hs_times[i] - hs_times[i-1]), 64'(3));

    // ---- push and pop on the same edge with two entries stored
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 3; i++) begin
      rand_cmd();
      step();
    end
    cmd_valid = 1'b0;
    wait_rsp("pp", n);
    rand_cmd();
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("pp_after_ready", 64'(cmd_ready), 64'(1));
    rand_cmd();
    step();
    check("pp_three_ready", 64'(cmd_ready), 64'(1));
    rand_cmd();
    step();
    check("pp_four_ready", 64'(cmd_ready), 64'(0));
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("pp");
    check("pp_rsp_count", 64'(n_rsp - base), 64'(6));

    // ---- random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) rand_cmd();
      else cmd_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
